// File: rtl/spram_pkg.sv
// Shared constants and state type for the SPRAM stream reader.
package spram_pkg;

  localparam int SPRAM_WORDS = 32768;
  localparam int ADDR_W      = $clog2(SPRAM_WORDS);
  localparam int DATA_W      = 32;
  localparam int BANK_BIT    = 14;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/spram_stream_reader_fifo.sv
// Synchronous FIFO between the SPRAM read port and the output stream.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spram_stream_reader.sv
// Read engine: fetches a run of SPRAM words through an arbitrated port and
// streams them out on a valid/ready interface.
module spram_stream_reader
  import spram_pkg::*;
#(
  parameter int ADDR_W     = spram_pkg::ADDR_W,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              ram_req,
  input  logic              ram_gnt,
  output logic              ram_select,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] hold_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_out;
  logic              has_space;
  logic              bubble;
  logic              issue;
  logic              last_issue;
  logic              start_accept;
  logic              pop;

  // In-flight reads are counted against FIFO space so no returning word is dropped.
  assign has_space    = (fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH);
  // The data cycle still muxes by the previous bank; a bank change must wait it out.
  assign bubble       = inflight_q && (addr_q[BANK_BIT] != hold_q[BANK_BIT]);
  assign issue        = ram_select;
  assign last_issue   = issue && (remaining_q == LEN_W'(1));
  assign start_accept = (state_q == IDLE) && start && !abort;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: default first so no path through the block leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = (length == '0) ? DONE : RUN;
        RUN:     if (last_issue) state_d = DRAIN;
        DRAIN:   if (!inflight_q && fifo_empty) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    ram_req    = (state_q == RUN) && has_space && !bubble;
    ram_select = ram_req && ram_gnt && !abort;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q          <= '0;
      hold_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      if (start_accept) begin
        addr_q      <= base_addr;
        remaining_q <= length;
      end else if (issue) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
        hold_q      <= addr_q;
      end
    end
  end

  // Outside issue cycles the port shows the last issued address, keeping its bank.
  assign ram_addr = ram_select ? addr_q : hold_q;
  assign ram_wen  = '0;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (abort),
    .push      (inflight_q),
    .push_data ({inflight_last_q, ram_rdata}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_out[DATA_W-1:0];
  assign m_last  = m_valid && fifo_out[DATA_W];
  assign pop     = m_valid && m_ready;

endmodule

// File: tb/tb_spram_stream_reader.sv
// Scoreboard bench for spram_stream_reader with a banked SPRAM model.
module tb_spram_stream_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        ram_req;
  logic        ram_gnt;
  logic        ram_select;
  logic [3:0]  ram_wen;
  logic [14:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  always #5 clk = ~clk;

  spram_stream_reader dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_req    (ram_req),
    .ram_gnt    (ram_gnt),
    .ram_select (ram_select),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  function automatic logic [31:0] ram_word(input logic [14:0] a);
    return 32'hA500_0000 + {17'd0, a};
  endfunction

  // SPRAM model: one-cycle read latency, output muxed by the live ram_addr[14].
  logic        sel_n    = 1'b0;
  logic [14:0] addr_n   = '0;
  logic        dcyc     = 1'b0;
  logic [14:0] lat_addr = '0;
  always @(negedge clk) begin
    sel_n  <= ram_select;
    addr_n <= ram_addr;
  end
  always @(posedge clk) begin
    dcyc     <= sel_n;
    lat_addr <= addr_n;
  end
  assign ram_rdata = dcyc ? ram_word({ram_addr[14], lat_addr[13:0]}) : 32'hDEAD_BEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Grant and ready drivers: 0 = always high, 1 = random / forced low, 2 = pattern / random.
  int       gnt_mode   = 0;
  int       ready_mode = 0;
  bit [5:0] gnt_pat    = 6'b101001;
  int       pat_i      = 0;
  initial begin
    ram_gnt = 1'b1;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        0:       ram_gnt = 1'b1;
        1:       ram_gnt = ($urandom_range(0, 9) < 7);
        default: begin ram_gnt = gnt_pat[pat_i]; pat_i = (pat_i + 1) % 6; end
      endcase
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model state: expected {last, data} words and expected issue addresses.
  logic [32:0] exp_q[$];
  logic [14:0] iss_q[$];
  int          iss_cyc[$];
  int          done_cnt  = 0;
  int          done_base = 0;
  bit          hold_prev = 0;
  logic [31:0] hold_data = '0;
  bit          prev_done = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      hold_prev = 0;
      prev_done = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hold_data);
      end
      hold_prev = m_valid && !m_ready && !abort;
      hold_data = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", m_data, 0);
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("m_data", m_data, e[31:0]);
          check("m_last", m_last, e[32]);
        end
      end
      if (ram_select) begin
        check("select_needs_gnt", ram_gnt, 1);
        if (iss_q.size() == 0) check("unexpected_issue", ram_addr, 0);
        else check("issue_addr", ram_addr, iss_q.pop_front());
        iss_cyc.push_back(cyc);
      end
      if (done) begin
        check("done_one_cycle", prev_done, 0);
        done_cnt++;
      end
      prev_done = done;
    end
  end

  task automatic start_xfer(input logic [14:0] b, input logic [15:0] l, input bit accept);
    logic [14:0] a;
    if (accept) begin
      done_base = done_cnt;
      iss_cyc.delete();
      for (int i = 0; i < int'(l); i++) begin
        a = b + 15'(i);
        exp_q.push_back({(i == int'(l) - 1), ram_word(a)});
        iss_q.push_back(a);
      end
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", (done_cnt != done_base), 1);
    repeat (2) @(posedge clk);
    #2;
    check("done_count", done_cnt - done_base, 1);
    check("idle_after", busy, 0);
    check("words_left", exp_q.size(), 0);
    check("issues_left", iss_q.size(), 0);
  endtask

  task automatic wait_issues(input int n_iss, input int budget);
    int n;
    n = 0;
    while (iss_cyc.size() < n_iss && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("issues_reached", (iss_cyc.size() >= n_iss), 1);
  endtask

  task automatic check_gaps(input int n_iss, input int bubble_idx);
    check("issue_count", iss_cyc.size(), n_iss);
    for (int i = 1; i < iss_cyc.size(); i++)
      check("issue_gap", iss_cyc[i] - iss_cyc[i-1], (i == bubble_idx) ? 2 : 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", ram_req, 0);
    check("rst_select", ram_select, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_wen", ram_wen, 0);
  endtask

  initial begin
    logic [14:0] b;
    resetn = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    @(posedge clk); #1;
    resetn = 1'b1;

    // Basic read
    start_xfer(15'h0010, 16'd4, 1);
    wait_done(200);
    check_gaps(4, -1);

    // Bank crossing and address wrap
    start_xfer(15'h3FFE, 16'd4, 1);
    wait_done(200);
    check_gaps(4, 2);
    start_xfer(15'h7FFF, 16'd2, 1);
    wait_done(200);
    check_gaps(2, 1);

    // Backpressure
    ready_mode = 1;
    start_xfer(15'h0200, 16'd10, 1);
    repeat (20) @(posedge clk);
    #2;
    check("bp_issues", iss_cyc.size(), 4);
    check("bp_valid", m_valid, 1);
    check("bp_req", ram_req, 0);
    ready_mode = 0;
    wait_done(300);

    // Grant toggling
    gnt_mode = 2;
    start_xfer(15'h0123, 16'd8, 1);
    wait_done(300);
    gnt_mode = 0;

    // Abort on the third issue
    start_xfer(15'h0040, 16'd16, 1);
    wait_issues(2, 100);
    #1;
    abort = 1'b1;
    @(posedge clk);
    exp_q.delete();
    iss_q.delete();
    #1;
    abort = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", m_valid, 0);
    repeat (5) @(posedge clk);
    #2;
    check("abort_no_done", done_cnt - done_base, 0);
    start_xfer(15'h0100, 16'd2, 1);
    wait_done(200);

    // Zero length
    start_xfer(15'h0555, 16'd0, 1);
    wait_done(50);
    check("zero_len_issues", iss_cyc.size(), 0);

    // Start while busy is ignored
    gnt_mode = 1; ready_mode = 2;
    start_xfer(15'h0400, 16'd8, 1);
    repeat (2) @(posedge clk);
    start_xfer(15'h0600, 16'd5, 0);
    wait_done(500);

    // Reset mid-RUN
    gnt_mode = 0; ready_mode = 0;
    start_xfer(15'h0300, 16'd16, 1);
    wait_issues(3, 100);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    exp_q.delete();
    iss_q.delete();
    #2;
    check_reset_outputs();
    @(posedge clk); #1;
    resetn = 1'b1;

    // Randomized transfers, biased toward bank edges
    gnt_mode = 1; ready_mode = 2;
    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0:       b = 15'h3FFC + 15'($urandom_range(0, 3));
        1:       b = 15'h7FFC + 15'($urandom_range(0, 3));
        default: b = 15'($urandom);
      endcase
      start_xfer(b, 16'($urandom_range(0, 12)), 1);
      wait_done(2000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spram_stream_reader.md
Name: spram_stream_reader

Overview:
- Bus-master read engine for the 128 kB SPRAM block; drives its select/wen/addr port and consumes its rdata.
- Reads a programmed run of 32-bit words and presents them on a valid/ready stream for video, UART or SPI consumers.
- Shares the SPRAM with the CPU through a req/gnt arbiter, buffers read data in a small FIFO, and never writes.

Parameters:
- ADDR_W, 15, SPRAM word-address width.
- LEN_W, 16, transfer length width in words.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; latches base_addr/length; ignored while busy.
- abort  in  1  stop the transfer and flush.
- base_addr  in  ADDR_W  first word address.
- length  in  LEN_W  number of words; 0 is legal.
- busy  out  1  transfer active.
- done  out  1  one-cycle completion pulse.
- ram_req  out  1  request for the SPRAM port.
- ram_gnt  in  1  port granted this cycle.
- ram_select  out  1  SPRAM select; high only in issue cycles.
- ram_wen  out  4  tied 0.
- ram_addr  out  ADDR_W  SPRAM word address.
- ram_rdata  in  32  SPRAM read data, valid one cycle after issue.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer ready.
- m_data  out  32  stream word.
- m_last  out  1  final word of the transfer; qualified by m_valid.

Behaviour:
- Reset: while resetn=0 at a clk edge, busy=0, done=0, ram_req=0, ram_select=0, ram_addr=0, m_valid=0, m_last=0, FIFO empty, state IDLE.
- States:
  - IDLE: on start with length=0, go to DONE with no reads. On start with length>0, latch the address and the remaining count, then go to RUN.
  - RUN: issue reads. After the last issue, go to DRAIN.
  - DRAIN: wait until no read is in flight and the FIFO is empty, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy is high in RUN, DRAIN and DONE.
- Issue rule: an issue happens in a cycle where all of these hold:
  - state is RUN;
  - ram_gnt=1;
  - FIFO count + in-flight < FIFO_DEPTH;
  - no bank bubble is required.
- In an issue cycle, ram_select=1, ram_addr=current address; the address then increments and the remaining count decrements.
- ram_req is high in RUN whenever an issue is otherwise permitted.
- Read latency: ram_rdata is captured into the FIFO at the edge after the issue edge. m_valid can rise at that edge, so a word reaches the stream at the earliest 2 cycles after its issue.
- Bank rule: SPRAM read data is muxed by ram_addr[14] in the data cycle.
  - ram_addr must keep bit 14 of the issued address through the data cycle.
  - Back-to-back issues are allowed within a bank.
  - When the next address differs in bit 14 (0x3FFF→0x4000, or wrap 0x7FFF→0x0000), insert exactly one non-issue cycle with ram_addr held at the previous address.
- Outside issue and data cycles, ram_addr holds its last value.
- Address wraps modulo 2^ADDR_W.
- Stream: a word transfers on m_valid & m_ready. m_data and m_valid stay stable while m_valid=1 and m_ready=0. FIFO write and read in the same cycle leave the count unchanged.
- m_last is set on the word that was issued with remaining count 1.
- abort: has priority over start and over everything else.
  - In any state, the next state is IDLE with busy=0.
  - The FIFO is flushed and m_valid=0.
  - In-flight data is discarded.
  - done is not pulsed.
- A start arriving while busy is ignored. start and abort together means abort.
- Reset mid-transfer behaves the same as abort, and all outputs take their reset values.
- ram_gnt dropping mid-RUN stalls issue only; it causes no data loss and no duplicate reads.

Decomposition:
- Shared package spram_pkg holds:
  - ADDR_W=15, DATA_W=32, BANK_BIT=14, SPRAM_WORDS=32768;
  - state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, stream_fifo: synchronous FIFO, DEPTH/WIDTH parameters, with 33-bit entries carrying {last, data}, push/pop/count/flush ports.
- The controller FSM, issue logic and bank bubble stay in the top module.

Test Plan:
- Basic read: RAM[n]=0xA5000000+n, base=0x0010, length=4, gnt=1, m_ready=1 → issues at 0x10..0x13 on consecutive cycles. Stream carries 0xA5000010..0xA5000013 with m_last on the 4th word. Exactly one done pulse, then busy=0.
- Bank crossing: base=0x3FFE, length=4 → exactly one bubble cycle between issue 0x3FFF and 0x4000, and all 4 words are correct. The same check on base=0x7FFF, length=2 confirms the wrap to 0x0000 with one bubble.
- Backpressure: m_ready=0 for 20 cycles, length=10 → issues stop after FIFO_DEPTH (4) words. After m_ready=1, all 10 words arrive in order with none duplicated.
- Grant toggling: ram_gnt pattern 1,0,0,1,0,1… with length=8 → ram_select appears only when gnt=1, and stream data stays in order.
- Abort: abort on the 3rd issue of a length=16 transfer → next cycle busy=0, m_valid=0, no done. A following start with base=0x0100, length=2 returns only RAM[0x100] and RAM[0x101].
- Edge cases: start with length=0 → done pulse with no ram_select. A second start while busy is ignored. Reset asserted mid-RUN → all outputs return to their reset values.
